// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse-parameter readback frame: header, length,
// per-field byte positions (reused by the host-side decoder) and FSM state types.
package pulse_pkg;

   localparam logic [7:0] FRAME_HDR = 8'hA5;
   localparam int         FRAME_LEN = 25;

   localparam logic [4:0] IDX_HDR    = 5'd0;
   localparam logic [4:0] IDX_PER    = 5'd1;
   localparam logic [4:0] IDX_P1WID  = 5'd5;
   localparam logic [4:0] IDX_DEL    = 5'd7;
   localparam logic [4:0] IDX_P2WID  = 5'd9;
   localparam logic [4:0] IDX_P1WID2 = 5'd11;
   localparam logic [4:0] IDX_DEL2   = 5'd13;
   localparam logic [4:0] IDX_P2WID2 = 5'd15;
   localparam logic [4:0] IDX_P1ST2  = 5'd17;
   localparam logic [4:0] IDX_NUT_D  = 5'd19;
   localparam logic [4:0] IDX_NUT_W  = 5'd21;
   localparam logic [4:0] IDX_PR_ATT = 5'd22;
   localparam logic [4:0] IDX_FLAGS  = 5'd23;
   localparam logic [4:0] IDX_CKSUM  = 5'd24;

   typedef enum logic {
      FR_IDLE,
      FR_SEND
   } frame_state_e;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer, LSB first. byte_done is high during the final cycle of
// the stop bit so the next byte can be started with no idle gap.
module uart_tx_byte
   import pulse_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       byte_done
);

   localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);

   tx_state_e     state_q;
   logic [BW-1:0] baud_q;
   logic [2:0]    bit_q;
   logic [7:0]    shift_q;
   logic          tx_q;
   logic          done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= TX_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            TX_IDLE: begin
               if (start) begin
                  shift_q <= data;
                  tx_q    <= 1'b0;
                  baud_q  <= '0;
                  state_q <= TX_START;
               end
            end
            TX_START: begin
               if (baud_q == BAUD_LAST) begin
                  baud_q  <= '0;
                  bit_q   <= '0;
                  tx_q    <= shift_q[0];
                  state_q <= TX_DATA;
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            TX_DATA: begin
               if (baud_q == BAUD_LAST) begin
                  baud_q <= '0;
                  if (bit_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= TX_STOP;
                  end else begin
                     bit_q   <= bit_q + 1'b1;
                     shift_q <= {1'b0, shift_q[7:1]};
                     tx_q    <= shift_q[1];
                  end
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            TX_STOP: begin
               // Raise byte_done one cycle early so it lines up with the last stop cycle.
               if (baud_q == BAUD_PRE) done_q <= 1'b1;
               if (baud_q == BAUD_LAST) begin
                  baud_q <= '0;
                  if (start) begin
                     shift_q <= data;
                     tx_q    <= 1'b0;
                     state_q <= TX_START;
                  end else begin
                     state_q <= TX_IDLE;
                  end
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            default: state_q <= TX_IDLE;
         endcase
      end
   end

   assign tx        = tx_q;
   assign byte_done = done_q;

endmodule

// File: rtl/param_readback_tx.sv
// Snapshots the live pulse parameters on request and sends them to the host as
// one 25-byte checksummed frame through uart_tx_byte.
module param_readback_tx
   import pulse_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic [31:0] per,
   input  logic [15:0] p1wid,
   input  logic [15:0] del,
   input  logic [15:0] p2wid,
   input  logic [15:0] p1wid2,
   input  logic [15:0] del2,
   input  logic [15:0] p2wid2,
   input  logic [15:0] p1st2,
   input  logic [15:0] nut_d,
   input  logic [7:0]  nut_w,
   input  logic [6:0]  pr_att,
   input  logic        cp,
   input  logic        bl,
   output logic        tx,
   output logic        busy,
   output logic        done
);

   frame_state_e state_q;
   logic [199:0] snap_q;
   logic [4:0]   idx_q;
   logic [7:0]   cksum_q;

   logic [4:0]   idx_d;
   logic [7:0]   cksum_d;
   logic [199:0] snap_shifted;
   logic [7:0]   nxt_byte;
   logic         accept;
   logic         last_byte;
   logic         advance;
   logic         ser_start;
   logic [7:0]   ser_data;
   logic         byte_done;

   // The snapshot is laid out as the frame image, byte 0 in the top bits;
   // the header and checksum slots are never read from it.
   always_comb begin
      accept       = req && (state_q == FR_IDLE);
      last_byte    = (idx_q == IDX_CKSUM);
      advance      = byte_done && (state_q == FR_SEND) && !last_byte;
      idx_d        = idx_q + 5'd1;
      snap_shifted = snap_q << {idx_d, 3'b000};
      nxt_byte     = (idx_d == IDX_CKSUM) ? cksum_q : snap_shifted[199:192];
      cksum_d      = (idx_d <= IDX_FLAGS) ? (cksum_q + nxt_byte) : cksum_q;
      ser_start    = accept || advance;
      ser_data     = accept ? FRAME_HDR : nxt_byte;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FR_IDLE;
         snap_q  <= '0;
         idx_q   <= '0;
         cksum_q <= '0;
      end else begin
         unique case (state_q)
            FR_IDLE: begin
               if (req) begin
                  snap_q  <= {FRAME_HDR, per, p1wid, del, p2wid, p1wid2, del2,
                              p2wid2, p1st2, nut_d, nut_w, {1'b0, pr_att},
                              {6'b0, cp, bl}, 8'h00};
                  idx_q   <= '0;
                  cksum_q <= '0;
                  state_q <= FR_SEND;
               end
            end
            FR_SEND: begin
               if (byte_done) begin
                  if (last_byte) begin
                     state_q <= FR_IDLE;
                  end else begin
                     idx_q   <= idx_d;
                     cksum_q <= cksum_d;
                  end
               end
            end
            default: state_q <= FR_IDLE;
         endcase
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_ser (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (ser_start),
      .data      (ser_data),
      .tx        (tx),
      .byte_done (byte_done)
   );

   assign busy = (state_q == FR_SEND);
   assign done = byte_done && (state_q == FR_SEND) && last_byte;

endmodule

// File: tb/tb_param_readback_tx.sv
// Bench for param_readback_tx: frames are predicted at request time into a byte
// queue and compared against bytes decoded from the serial line.
module tb_param_readback_tx;

   logic        clk;
   logic        rst_n;
   logic        req1, req2;
   logic [31:0] per;
   logic [15:0] w16 [8];
   logic [7:0]  nut_w;
   logic [6:0]  pr_att;
   logic        cp, bl;
   logic        tx1, busy1, done1;
   logic        tx2, busy2, done2;

   logic [7:0]  exp_q [$];
   int          n_checks;
   int          n_pass;

   param_readback_tx #(.CLKS_PER_BIT(4)) dut (
      .clk(clk), .rst_n(rst_n), .req(req1), .per(per),
      .p1wid(w16[0]), .del(w16[1]), .p2wid(w16[2]), .p1wid2(w16[3]),
      .del2(w16[4]), .p2wid2(w16[5]), .p1st2(w16[6]), .nut_d(w16[7]),
      .nut_w(nut_w), .pr_att(pr_att), .cp(cp), .bl(bl),
      .tx(tx1), .busy(busy1), .done(done1)
   );

   param_readback_tx #(.CLKS_PER_BIT(104)) dut104 (
      .clk(clk), .rst_n(rst_n), .req(req2), .per(per),
      .p1wid(w16[0]), .del(w16[1]), .p2wid(w16[2]), .p1wid2(w16[3]),
      .del2(w16[4]), .p2wid2(w16[5]), .p1st2(w16[6]), .nut_d(w16[7]),
      .nut_w(nut_w), .pr_att(pr_att), .cp(cp), .bl(bl),
      .tx(tx2), .busy(busy2), .done(done2)
   );

   always #5 clk = ~clk;

   function automatic void build_frame(output logic [7:0] f [25]);
      logic [7:0] sum;
      f[0] = 8'hA5;
      f[1] = per[31:24]; f[2] = per[23:16]; f[3] = per[15:8]; f[4] = per[7:0];
      for (int i = 0; i < 8; i++) begin
         f[5 + 2*i] = w16[i][15:8];
         f[6 + 2*i] = w16[i][7:0];
      end
      f[21] = nut_w;
      f[22] = {1'b0, pr_att};
      f[23] = {6'b0, cp, bl};
      sum = 8'h00;
      for (int k = 1; k <= 23; k++) sum = sum + f[k];
      f[24] = sum;
   endfunction

   task automatic push_frame(output logic [7:0] f [25]);
      build_frame(f);
      for (int k = 0; k < 25; k++) exp_q.push_back(f[k]);
   endtask

   function automatic logic exp_tx(input logic [7:0] f [25], input int n, input int cpb);
      int idx, bi;
      if (n < 1 || n > 250*cpb) return 1'b1;
      idx = (n - 1) / cpb;
      bi  = idx % 10;
      if (bi == 0) return 1'b0;
      if (bi == 9) return 1'b1;
      return f[idx/10][bi-1];
   endfunction

   // Pulses req, then watches the line for up to 'limit' cycles after the request.
   // act: 0 plain, 1 change per at byte 2, 2 extra reqs while busy, 3 reset at byte 12.
   task automatic frame_run(input int sel, input int act, input int limit,
                            input logic [7:0] ef [25], output logic [7:0] rx [25],
                            output int done_cyc, output int done_cnt,
                            output int tx_bad, output int busy_bad);
      int cpb, idx, pos;
      logic t, b, d;
      cpb = (sel == 1) ? 104 : 4;
      done_cyc = -1; done_cnt = 0; tx_bad = 0; busy_bad = 0;
      for (int k = 0; k < 25; k++) rx[k] = 8'h00;
      @(negedge clk);
      if (sel == 1) req2 = 1'b1; else req1 = 1'b1;
      for (int n = 1; n <= limit; n++) begin
         @(negedge clk);
         req1 = 1'b0; req2 = 1'b0;
         if (act == 1 && n == 20*cpb + 1) per = 32'hFFFF_FFFF;
         if (act == 2 && (n == 10 || n == 500 || n == 250*cpb)) req1 = 1'b1;
         if (act == 3 && n == 120*cpb + 1) begin
            rst_n = 1'b0;
            #1;
            break;
         end
         t = (sel == 1) ? tx2 : tx1;
         b = (sel == 1) ? busy2 : busy1;
         d = (sel == 1) ? done2 : done1;
         if (t !== exp_tx(ef, n, cpb)) tx_bad++;
         if (b !== (n <= 250*cpb)) busy_bad++;
         if (d === 1'b1) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = n;
         end
         idx = (n - 1) / cpb;
         pos = (n - 1) % cpb;
         if (pos == cpb/2 && idx < 250 && (idx % 10) >= 1 && (idx % 10) <= 8)
            rx[idx/10][(idx%10)-1] = t;
      end
   endtask

   task automatic set_populated();
      per = 32'h1234_5678;
      for (int i = 0; i < 8; i++) w16[i] = 16'h0000;
      w16[0] = 16'h0001;
      nut_w = 8'h10; pr_att = 7'h7F; cp = 1'b1; bl = 1'b1;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_checks++; if (tx1 !== 1'b1) $display("FAIL reset_tx got %b want 1", tx1); else n_pass++;
      n_checks++; if (busy1 !== 1'b0) $display("FAIL reset_busy got %b want 0", busy1); else n_pass++;
      n_checks++; if (done1 !== 1'b0) $display("FAIL reset_done got %b want 0", done1); else n_pass++;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++; if ({tx1, busy1, done1, tx2, busy2} !== 5'b10010)
         $display("FAIL post_reset_idle got %b want 10010", {tx1, busy1, done1, tx2, busy2});
      else n_pass++;
   endtask

   task automatic test_all_zero();
      logic [7:0] ef [25], rx [25];
      int dc, dn, tb_, bb;
      per = '0; for (int i = 0; i < 8; i++) w16[i] = '0;
      nut_w = '0; pr_att = '0; cp = 1'b0; bl = 1'b0;
      push_frame(ef);
      frame_run(0, 0, 1008, ef, rx, dc, dn, tb_, bb);
      for (int k = 0; k < 25; k++) begin
         logic [7:0] e;
         e = exp_q.pop_front();
         n_checks++; if (rx[k] !== e) $display("FAIL zero_byte%0d got %02h want %02h", k, rx[k], e); else n_pass++;
      end
      n_checks++; if (dc !== 1000) $display("FAIL zero_done_cycle got %0d want 1000", dc); else n_pass++;
      n_checks++; if (dn !== 1) $display("FAIL zero_done_count got %0d want 1", dn); else n_pass++;
      n_checks++; if (tb_ !== 0) $display("FAIL zero_tx_wave got %0d bad cycles want 0", tb_); else n_pass++;
      n_checks++; if (bb !== 0) $display("FAIL zero_busy got %0d bad cycles want 0", bb); else n_pass++;
   endtask

   task automatic test_populated();
      logic [7:0] ef [25], rx [25];
      int dc, dn, tb_, bb;
      set_populated();
      push_frame(ef);
      frame_run(0, 0, 1008, ef, rx, dc, dn, tb_, bb);
      for (int k = 0; k < 25; k++) begin
         logic [7:0] e;
         e = exp_q.pop_front();
         n_checks++; if (rx[k] !== e) $display("FAIL pop_byte%0d got %02h want %02h", k, rx[k], e); else n_pass++;
      end
      n_checks++; if (rx[24] !== 8'hA7) $display("FAIL pop_checksum got %02h want a7", rx[24]); else n_pass++;
      n_checks++; if (dc !== 1000) $display("FAIL pop_done_cycle got %0d want 1000", dc); else n_pass++;
      n_checks++; if (tb_ !== 0) $display("FAIL pop_tx_wave got %0d bad cycles want 0", tb_); else n_pass++;
   endtask

   task automatic test_snapshot();
      logic [7:0] ef [25], rx [25];
      int dc, dn, tb_, bb;
      set_populated();
      push_frame(ef);
      frame_run(0, 1, 1008, ef, rx, dc, dn, tb_, bb);
      per = 32'h1234_5678;
      for (int k = 0; k < 25; k++) begin
         logic [7:0] e;
         e = exp_q.pop_front();
         n_checks++; if (rx[k] !== e) $display("FAIL snap_byte%0d got %02h want %02h", k, rx[k], e); else n_pass++;
      end
      n_checks++; if (rx[24] !== 8'hA7) $display("FAIL snap_checksum got %02h want a7", rx[24]); else n_pass++;
      n_checks++; if (tb_ !== 0) $display("FAIL snap_tx_wave got %0d bad cycles want 0", tb_); else n_pass++;
   endtask

   task automatic test_req_while_busy();
      logic [7:0] ef [25], rx [25];
      int dc, dn, tb_, bb;
      set_populated();
      w16[3] = 16'hBEEF;
      push_frame(ef);
      frame_run(0, 2, 1000, ef, rx, dc, dn, tb_, bb);
      for (int k = 0; k < 25; k++) begin
         logic [7:0] e;
         e = exp_q.pop_front();
         n_checks++; if (rx[k] !== e) $display("FAIL busy_byte%0d got %02h want %02h", k, rx[k], e); else n_pass++;
      end
      n_checks++; if (dn !== 1) $display("FAIL busy_done_count got %0d want 1", dn); else n_pass++;
      n_checks++; if (dc !== 1000) $display("FAIL busy_done_cycle got %0d want 1000", dc); else n_pass++;
      n_checks++; if (tb_ !== 0 || bb !== 0) $display("FAIL busy_wave got tx %0d busy %0d bad want 0", tb_, bb); else n_pass++;
      w16[3] = 16'h0102;
      push_frame(ef);
      frame_run(0, 0, 1008, ef, rx, dc, dn, tb_, bb);
      for (int k = 0; k < 25; k++) begin
         logic [7:0] e;
         e = exp_q.pop_front();
         n_checks++; if (rx[k] !== e) $display("FAIL b2b_byte%0d got %02h want %02h", k, rx[k], e); else n_pass++;
      end
      n_checks++; if (dc !== 1000 || dn !== 1) $display("FAIL b2b_done got cycle %0d count %0d want 1000 1", dc, dn); else n_pass++;
      n_checks++; if (tb_ !== 0 || bb !== 0) $display("FAIL b2b_wave got tx %0d busy %0d bad want 0", tb_, bb); else n_pass++;
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] ef [25], rx [25];
      int dc, dn, tb_, bb, late_done;
      set_populated();
      push_frame(ef);
      frame_run(0, 3, 1008, ef, rx, dc, dn, tb_, bb);
      n_checks++; if (tx1 !== 1'b1) $display("FAIL midrst_tx got %b want 1", tx1); else n_pass++;
      n_checks++; if (busy1 !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy1); else n_pass++;
      repeat (25) void'(exp_q.pop_front());
      late_done = dn;
      repeat (3) begin
         @(negedge clk);
         if (done1 !== 1'b0) late_done++;
      end
      rst_n = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (done1 !== 1'b0 || tx1 !== 1'b1) late_done++;
      end
      n_checks++; if (late_done !== 0) $display("FAIL midrst_no_done got %0d events want 0", late_done); else n_pass++;
      w16[7] = 16'h5A5A;
      push_frame(ef);
      frame_run(0, 0, 1008, ef, rx, dc, dn, tb_, bb);
      for (int k = 0; k < 25; k++) begin
         logic [7:0] e;
         e = exp_q.pop_front();
         n_checks++; if (rx[k] !== e) $display("FAIL rec_byte%0d got %02h want %02h", k, rx[k], e); else n_pass++;
      end
      n_checks++; if (dc !== 1000 || dn !== 1) $display("FAIL rec_done got cycle %0d count %0d want 1000 1", dc, dn); else n_pass++;
   endtask

   task automatic test_default_rate();
      logic [7:0] ef [25], rx [25];
      int dc, dn, tb_, bb;
      set_populated();
      w16[2] = 16'hC3E1;
      push_frame(ef);
      frame_run(1, 0, 26008, ef, rx, dc, dn, tb_, bb);
      for (int k = 0; k < 25; k++) begin
         logic [7:0] e;
         e = exp_q.pop_front();
         n_checks++; if (rx[k] !== e) $display("FAIL rate_byte%0d got %02h want %02h", k, rx[k], e); else n_pass++;
      end
      n_checks++; if (dc !== 26000) $display("FAIL rate_done_cycle got %0d want 26000", dc); else n_pass++;
      n_checks++; if (tb_ !== 0) $display("FAIL rate_bit_width got %0d bad cycles want 0", tb_); else n_pass++;
      n_checks++; if (bb !== 0) $display("FAIL rate_busy got %0d bad cycles want 0", bb); else n_pass++;
   endtask

   initial begin
      clk = 1'b0; rst_n = 1'b0; req1 = 1'b0; req2 = 1'b0;
      per = '0; for (int i = 0; i < 8; i++) w16[i] = '0;
      nut_w = '0; pr_att = '0; cp = 1'b0; bl = 1'b0;
      n_checks = 0; n_pass = 0;
      test_reset();
      test_all_zero();
      test_populated();
      test_snapshot();
      test_req_while_busy();
      test_reset_mid_frame();
      test_default_rate();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
